bytecode_fetch: RTL

Initiator side of the byte-ROM read handshake. It walks a program counter through the bytecode ROM, issues one single-byte read per operand byte, and assembles 1–4 consecutive bytes big-endian into a 32-bit word, sign- or zero-extended. The word is presented to the decoder with a valid/ack handshake. It sits between the JVM decode/control FSM and the byte ROM responder.

---
 rtl/jvm_fetch_pkg.sv | 36 +++
 rtl/fetch_byte_asm.sv | 63 ++++++
 rtl/bytecode_fetch.sv | 104 ++++++++++
 3 files changed

// File: rtl/jvm_fetch_pkg.sv
// Shared definitions for the bytecode fetch unit: FSM state encoding, data
// widths, fetch_len byte-count encodings and the sign/zero extension helper.
package jvm_fetch_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_e;

  // fetch_len holds byte count minus one
  localparam logic [1:0] LEN_1B = 2'd0;
  localparam logic [1:0] LEN_2B = 2'd1;
  localparam logic [1:0] LEN_3B = 2'd2;
  localparam logic [1:0] LEN_4B = 2'd3;

  // Extend the low (len+1) bytes of acc to a full word.
  function automatic logic [WORD_W-1:0] extend_word(input logic [WORD_W-1:0] acc,
                                                    input logic [1:0]        len,
                                                    input logic              sgn);
    logic [WORD_W-1:0] w;
    w = acc;
    case (len)
      LEN_1B:  w = {{24{sgn & acc[7]}},  acc[7:0]};
      LEN_2B:  w = {{16{sgn & acc[15]}}, acc[15:0]};
      LEN_3B:  w = {{8{sgn & acc[23]}},  acc[23:0]};
      default: w = acc;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/fetch_byte_asm.sv
// Byte assembler for bytecode_fetch: big-endian shift accumulator, remaining
// byte counter and sign/zero extension of the assembled operand.
//   clear_i  : start a new operand (latches len_i / signed_i, clears acc)
//   shift_i  : shift byte_i into the accumulator, count one byte down
//   last_o   : the byte being received now is the final one
//   word_o   : extended word including any byte shifted in this cycle
module fetch_byte_asm
  import jvm_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic [1:0]        len_i,
  input  logic              signed_i,
  input  logic              shift_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic              last_o,
  output logic [WORD_W-1:0] word_o
);

  logic [WORD_W-1:0] acc_q, acc_d;
  logic [1:0]        rem_q, rem_d;
  logic [1:0]        len_q, len_d;
  logic              sgn_q, sgn_d;

  always_comb begin
    acc_d = acc_q;
    rem_d = rem_q;
    len_d = len_q;
    sgn_d = sgn_q;
    if (clear_i) begin
      acc_d = '0;
      rem_d = len_i;
      len_d = len_i;
      sgn_d = signed_i;
    end else if (shift_i) begin
      acc_d = {acc_q[WORD_W-BYTE_W-1:0], byte_i};
      if (rem_q != '0) begin
        rem_d = rem_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      rem_q <= '0;
      len_q <= '0;
      sgn_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      rem_q <= rem_d;
      len_q <= len_d;
      sgn_q <= sgn_d;
    end
  end

  assign last_o = (rem_q == '0);
  // Built from acc_d so the parent can register the finished word on the
  // same edge that captures the final byte.
  assign word_o = extend_word(acc_d, len_q, sgn_q);

endmodule

// File: rtl/bytecode_fetch.sv
// Initiator side of the byte-ROM read handshake. Walks the PC through the
// bytecode ROM, issuing one single-byte read per operand byte, and presents
// a 1-4 byte big-endian operand (sign/zero extended) with valid/ack.
//   fetch/fetch_len/fetch_signed : operand request, accepted while ready
//   pc_load/pc_value             : jump, honoured while ready (before fetch)
//   valid/data_out/data_ack      : operand hand-off to the decoder
//   mem_*                        : ROM read handshake, mem_address == pc
module bytecode_fetch
  import jvm_fetch_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned RESET_PC      = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch,
  input  logic [1:0]               fetch_len,
  input  logic                     fetch_signed,
  input  logic                     pc_load,
  input  logic [ADDRESS_WIDTH-1:0] pc_value,
  input  logic                     data_ack,
  output logic                     ready,
  output logic                     valid,
  output logic [WORD_W-1:0]        data_out,
  output logic [ADDRESS_WIDTH-1:0] pc,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic                     mem_start,
  input  logic                     mem_ready,
  input  logic [BYTE_W-1:0]        mem_data
);

  fetch_state_e             state_q;
  logic [ADDRESS_WIDTH-1:0] pc_q;
  logic [WORD_W-1:0]        data_out_q;

  logic              asm_clear;
  logic              asm_shift;
  logic              asm_last;
  logic [WORD_W-1:0] asm_word;

  assign asm_clear = (state_q == ST_IDLE) && fetch;
  assign asm_shift = (state_q == ST_WAIT) && mem_ready;

  fetch_byte_asm u_asm (
    .clk      (clk),
    .rst_n    (reset),
    .clear_i  (asm_clear),
    .len_i    (fetch_len),
    .signed_i (fetch_signed),
    .shift_i  (asm_shift),
    .byte_i   (mem_data),
    .last_o   (asm_last),
    .word_o   (asm_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= ADDRESS_WIDTH'(RESET_PC);
      data_out_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pc_load) begin
            pc_q <= pc_value;
          end
          if (fetch) begin
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_ready) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_ready) begin
            pc_q <= pc_q + ADDRESS_WIDTH'(1);
            if (asm_last) begin
              state_q    <= ST_DONE;
              data_out_q <= asm_word;
            end else begin
              state_q <= ST_ISSUE;
            end
          end
        end
        ST_DONE: begin
          if (data_ack) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready       = (state_q == ST_IDLE);
  assign valid       = (state_q == ST_DONE);
  assign data_out    = data_out_q;
  assign pc          = pc_q;
  assign mem_address = pc_q;
  assign mem_start   = (state_q == ST_ISSUE) && mem_ready;

endmodule
